// File: rtl/noise_stats_accum.sv
// Windowed sum / sum-of-squares / min / max over the 8x12-bit sample stream.
// Define NOISE_STATS_CLIP_EN to add the full-scale clip counter output clip_cnt_o.

module noise_stats_lane (
  input  logic               aclk,
  input  logic               rst_n,
  input  logic        [11:0] word,
  output logic signed [11:0] smp,
`ifdef NOISE_STATS_CLIP_EN
  output logic               clip,
`endif
  output logic        [22:0] sq
);
  // Square is computed mod 2^23; the true square never exceeds 2^22.
  logic [22:0] ext;
  assign ext = {{11{smp[11]}}, smp};

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      smp  <= '0;
      sq   <= '0;
`ifdef NOISE_STATS_CLIP_EN
      clip <= 1'b0;
`endif
    end else begin
      smp  <= word;
      sq   <= ext * ext;
`ifdef NOISE_STATS_CLIP_EN
      clip <= (smp == 12'h7FF) || (smp == 12'h800);
`endif
    end
  end
endmodule

module noise_stats_accum #(
  parameter int LOG2_BEATS = 10,
  parameter int SUM_W      = 15 + LOG2_BEATS,
  parameter int SQ_W       = 26 + LOG2_BEATS
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [127:0]            s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic signed [SUM_W-1:0] sum_o,
  output logic [SQ_W-1:0]         sumsq_o,
  output logic signed [11:0]      min_o,
`ifdef NOISE_STATS_CLIP_EN
  output logic [LOG2_BEATS+3:0]   clip_cnt_o,
`endif
  output logic signed [11:0]      max_o
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 2;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Reset asserts asynchronously, releases two clocks after aresetn rises.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n         = rst_sync[1];
  assign s_axis_tready = rst_n;

  state_t                state;
  logic [LOG2_BEATS-1:0] beat_cnt;
  logic [1:0]            flush_cnt;
  logic                  accept, start_go, abort_go, beat_in;
  logic [STAGES:1]       vld_pipe;

  assign accept   = s_axis_tvalid & s_axis_tready;
  assign start_go = (state == IDLE) & start_i;
  assign abort_go = ((state == RUN) | (state == FLUSH)) & abort_i;
  assign beat_in  = (state == RUN) & accept & ~abort_i;
  assign busy_o   = (state == RUN) | (state == FLUSH);

  // Per-lane S1 sample register and S2 square
  logic [NUM_LANES-1:0][11:0] s1_smp;
  logic [NUM_LANES-1:0][22:0] s2_sq;
  logic [NUM_LANES-1:0][3:0]  unused_nib;
`ifdef NOISE_STATS_CLIP_EN
  logic [NUM_LANES-1:0]       s2_clip;
`endif

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign unused_nib[gi] = s_axis_tdata[16*gi +: 4];
    noise_stats_lane u_lane (
      .aclk (aclk),
      .rst_n(rst_n),
      .word (s_axis_tdata[16*gi+4 +: 12]),
      .smp  (s1_smp[gi]),
`ifdef NOISE_STATS_CLIP_EN
      .clip (s2_clip[gi]),
`endif
      .sq   (s2_sq[gi])
    );
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n)        vld_pipe <= '0;
    else if (abort_go) vld_pipe <= '0;
    else               vld_pipe <= {vld_pipe[1], beat_in};
  end

  // S2: beat sum, min, max across lanes
  logic        [14:0] bsum;
  logic signed [11:0] bmin, bmax;
  always_comb begin
    bsum = '0;
    bmin = s1_smp[0];
    bmax = s1_smp[0];
    for (int i = 0; i < NUM_LANES; i++) begin
      bsum = bsum + {{3{s1_smp[i][11]}}, s1_smp[i]};
      if ($signed(s1_smp[i]) < bmin) bmin = s1_smp[i];
      if ($signed(s1_smp[i]) > bmax) bmax = s1_smp[i];
    end
  end

  logic        [14:0] s2_sum;
  logic signed [11:0] s2_min, s2_max;
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sum <= '0;
      s2_min <= '0;
      s2_max <= '0;
    end else begin
      s2_sum <= bsum;
      s2_min <= bmin;
      s2_max <= bmax;
    end
  end

  // S3: window accumulators
  logic [25:0] sqsum;
`ifdef NOISE_STATS_CLIP_EN
  logic [3:0]  clipsum;
`endif
  always_comb begin
    sqsum = '0;
    for (int i = 0; i < NUM_LANES; i++) sqsum = sqsum + {3'b0, s2_sq[i]};
  end
`ifdef NOISE_STATS_CLIP_EN
  always_comb begin
    clipsum = '0;
    for (int i = 0; i < NUM_LANES; i++) clipsum = clipsum + {3'b0, s2_clip[i]};
  end
`endif

  logic signed [SUM_W-1:0]      acc_sum;
  logic        [SQ_W-1:0]       acc_sq;
  logic signed [11:0]           acc_min, acc_max;
`ifdef NOISE_STATS_CLIP_EN
  logic        [LOG2_BEATS+3:0] acc_clip;
`endif

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum  <= '0;
      acc_sq   <= '0;
      acc_min  <= '0;
      acc_max  <= '0;
`ifdef NOISE_STATS_CLIP_EN
      acc_clip <= '0;
`endif
    end else if (start_go) begin
      acc_sum  <= '0;
      acc_sq   <= '0;
      acc_min  <= 12'h7FF;
      acc_max  <= 12'h800;
`ifdef NOISE_STATS_CLIP_EN
      acc_clip <= '0;
`endif
    end else if (vld_pipe[STAGES] && !abort_go) begin
      acc_sum <= acc_sum + {{(SUM_W-15){s2_sum[14]}}, s2_sum};
      acc_sq  <= acc_sq + {{(SQ_W-26){1'b0}}, sqsum};
      if (s2_min < acc_min) acc_min <= s2_min;
      if (s2_max > acc_max) acc_max <= s2_max;
`ifdef NOISE_STATS_CLIP_EN
      acc_clip <= acc_clip + {{LOG2_BEATS{1'b0}}, clipsum};
`endif
    end
  end

  // Control FSM; FLUSH holds 3 cycles so the last beat has left S3 before DONE.
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      flush_cnt  <= '0;
      done_o     <= 1'b0;
      sum_o      <= '0;
      sumsq_o    <= '0;
      min_o      <= '0;
      max_o      <= '0;
`ifdef NOISE_STATS_CLIP_EN
      clip_cnt_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            state    <= RUN;
            beat_cnt <= '0;
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (&beat_cnt) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (abort_i)                state     <= IDLE;
          else if (flush_cnt == 2'd2) state     <= DONE;
          else                        flush_cnt <= flush_cnt + 1'b1;
        end
        DONE: begin
          sum_o      <= acc_sum;
          sumsq_o    <= acc_sq;
          min_o      <= acc_min;
          max_o      <= acc_max;
`ifdef NOISE_STATS_CLIP_EN
          clip_cnt_o <= acc_clip;
`endif
          done_o     <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_noise_stats_accum.sv
// Directed bench for noise_stats_accum at LOG2_BEATS=4 (16-beat windows).

module tb_noise_stats_accum;
  localparam int LB    = 4;
  localparam int SUM_W = 15 + LB;
  localparam int SQ_W  = 26 + LB;

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [127:0]            s_axis_tdata = '0;
  logic                    s_axis_tvalid = 1'b0;
  logic                    s_axis_tready;
  logic                    start_i = 1'b0;
  logic                    abort_i = 1'b0;
  logic                    busy_o, done_o;
  logic signed [SUM_W-1:0] sum_o;
  logic [SQ_W-1:0]         sumsq_o;
  logic signed [11:0]      min_o, max_o;
`ifdef NOISE_STATS_CLIP_EN
  logic [LB+3:0]           clip_cnt_o;
`endif

  noise_stats_accum #(.LOG2_BEATS(LB)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .sum_o        (sum_o),
    .sumsq_o      (sumsq_o),
    .min_o        (min_o),
`ifdef NOISE_STATS_CLIP_EN
    .clip_cnt_o   (clip_cnt_o),
`endif
    .max_o        (max_o)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] w);
    return {8{w}};
  endfunction

  // Pulse start (optionally with abort), stream data, return cycles from the
  // start edge to the first done_o (-1 on timeout).
  task automatic run_window(input logic [127:0] data, input bit toggle,
                            input int restart_at, input bit with_abort,
                            output int lat);
    lat           = -1;
    s_axis_tdata  = data;
    s_axis_tvalid = 1'b1;
    start_i       = 1'b1;
    abort_i       = with_abort;
    @(posedge aclk); #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge aclk); #1;
      if (c == 1) chk("busy_run", busy_o, 1);
      if (done_o) begin
        lat = c;
        break;
      end
      if (toggle) s_axis_tvalid = ~s_axis_tvalid;
      start_i = (c == restart_at);
    end
    start_i = 1'b0;
  endtask

  int lat, ndone, nbusy;

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_sumsq", sumsq_o, 0);
    chk("rst_min", min_o, 0);
    chk("rst_max", max_o, 0);
    aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    chk("tready_on", s_axis_tready, 1);

    // all +1
    run_window(lanes(16'h0010), 1'b0, 0, 1'b0, lat);
    chk("p1_lat", lat, 20);
    chk("p1_sum", sum_o, 128);
    chk("p1_sumsq", sumsq_o, 128);
    chk("p1_min", min_o, 1);
    chk("p1_max", max_o, 1);
`ifdef NOISE_STATS_CLIP_EN
    chk("p1_clip", clip_cnt_o, 0);
`endif
    @(posedge aclk); #1;
    chk("p1_done_pulse", done_o, 0);
    chk("p1_idle", busy_o, 0);

    // all -2048
    run_window(lanes(16'h8000), 1'b0, 0, 1'b0, lat);
    chk("n_lat", lat, 20);
    chk("n_sum", sum_o, -262144);
    chk("n_sumsq", sumsq_o, 536870912);
    chk("n_min", min_o, -2048);
    chk("n_max", max_o, -2048);
`ifdef NOISE_STATS_CLIP_EN
    chk("n_clip", clip_cnt_o, 128);
`endif

    // +5/-5 alternating lanes, tvalid toggling
    run_window({4{16'hFFB0, 16'h0050}}, 1'b1, 0, 1'b0, lat);
    chk("alt_lat", lat, 35);
    chk("alt_sum", sum_o, 0);
    chk("alt_sumsq", sumsq_o, 3200);
    chk("alt_min", min_o, -5);
    chk("alt_max", max_o, 5);

    // abort after 7 beats
    s_axis_tdata  = lanes(16'h8000);
    s_axis_tvalid = 1'b1;
    start_i       = 1'b1;
    @(posedge aclk); #1;
    start_i = 1'b0;
    repeat (7) @(posedge aclk);
    #1;
    abort_i = 1'b1;
    @(posedge aclk); #1;
    abort_i = 1'b0;
    chk("abort_idle", busy_o, 0);
    ndone = 0;
    repeat (10) begin
      @(posedge aclk); #1;
      if (done_o) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_hold_sum", sum_o, 0);
    chk("abort_hold_sumsq", sumsq_o, 3200);
    chk("abort_hold_min", min_o, -5);
    run_window(lanes(16'h0010), 1'b0, 0, 1'b0, lat);
    chk("post_abort_lat", lat, 20);
    chk("post_abort_sum", sum_o, 128);
    chk("post_abort_min", min_o, 1);

    // beats streamed while idle are discarded
    s_axis_tdata  = lanes(16'h8000);
    s_axis_tvalid = 1'b1;
    ndone = 0;
    nbusy = 0;
    repeat (6) begin
      @(posedge aclk); #1;
      if (done_o) ndone++;
      if (busy_o) nbusy++;
    end
    chk("idle_nodone", ndone, 0);
    chk("idle_nobusy", nbusy, 0);

    // start+abort together in IDLE (start wins), repeated start mid-RUN
    run_window(lanes(16'h0010), 1'b0, 5, 1'b1, lat);
    chk("restart_lat", lat, 20);
    chk("restart_sum", sum_o, 128);
    chk("restart_sumsq", sumsq_o, 128);

    // start landing in the DONE cycle is ignored
    run_window(lanes(16'h0010), 1'b0, 19, 1'b0, lat);
    chk("done_start_lat", lat, 20);
    @(posedge aclk); #1;
    chk("done_start_ignored", busy_o, 0);

    // async reset mid-RUN
    s_axis_tdata  = lanes(16'h8000);
    s_axis_tvalid = 1'b1;
    start_i       = 1'b1;
    @(posedge aclk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("arst_sum", sum_o, 0);
    chk("arst_sumsq", sumsq_o, 0);
    chk("arst_min", min_o, 0);
    chk("arst_max", max_o, 0);
    chk("arst_tready", s_axis_tready, 0);
    chk("arst_busy", busy_o, 0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("arst_tready_back", s_axis_tready, 1);
    ndone = 0;
    nbusy = 0;
    repeat (25) begin
      @(posedge aclk); #1;
      if (done_o) ndone++;
      if (busy_o) nbusy++;
    end
    chk("arst_nodone", ndone, 0);
    chk("arst_nobusy", nbusy, 0);
    run_window(lanes(16'h0010), 1'b0, 0, 1'b0, lat);
    chk("arst_win_lat", lat, 20);
    chk("arst_win_sum", sum_o, 128);
    chk("arst_win_max", max_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
